min_index_seq: RTL and testbench
================================

# min_index_seq

Sequential argmin engine for the colour-classification path. Scans six candidate distances from a synchronous-read register file and returns the index and value of the smallest. It sits between the sticker-sampling logic, which writes per-colour distances, and the face-map writer, which consumes the 3-bit colour index. It replaces the six-wide parallel comparator tree with one shared comparator, sequenced over six reads.

## Interface

- `WIDTH`, 16, bit width of each distance value (unsigned)
- `N_CAND`, 6, number of candidates; fixed at 6, index width 3

- `clock`  in  1  single clock, rising edge
- `reset`  in  1  synchronous, active-high
- `start`  in  1  begin a scan; sampled only in IDLE
- `rd_en`  out  1  read strobe to register file
- `rd_addr`  out  3  candidate address, 0..5
- `rd_data`  in  WIDTH  distance for address presented on the previous cycle's `rd_en`
- `busy`  out  1  high in SCAN and DRAIN
- `done`  out  1  one-cycle pulse; result valid
- `min_index`  out  3  index of minimum, 0..5
- `min_value`  out  WIDTH  value of minimum

## Operation

- FSM states: IDLE, SCAN, DRAIN, DONE.
- IDLE: `rd_en`=0, `rd_addr`=0. When `start`=1, go to SCAN and clear the address counter.
- SCAN: `rd_en`=1, `rd_addr`=counter, counter +1 per cycle. After address 5 is issued, go to DRAIN.
- DRAIN: `rd_en`=0. Captures the last `rd_data`, then goes to DONE.
- DONE: `done`=1 for one cycle. Copy the running min/index into the `min_index`/`min_value` output registers. Return to IDLE.
- Running tracker:
  - A one-cycle delayed `rd_en` with its address marks valid `rd_data`.
  - The first valid sample (address 0) loads the tracker unconditionally.
  - Each later sample replaces the tracker only if `rd_data` < `min_value_run` (strict, unsigned).
  - Ties keep the lower index.
- Outputs `min_index`/`min_value` change only in DONE and hold between scans.
- `start` outside IDLE is ignored; it is not queued.
- `start` held high causes back-to-back scans, re-sampled on each IDLE cycle.
- All-equal inputs, including all `{WIDTH{1'b1}}`, give index 0.

## Timing

- Cycle 0: IDLE with `start`=1.
- Cycles 1–6: SCAN, `rd_addr` = 0..5.
- Cycles 2–7: data compared; cycle 7 is DRAIN.
- Cycle 8: DONE, `done`=1, outputs valid from cycle 8 onward.
- Cycle 9: IDLE. Earliest next `start` is sampled at cycle 9; minimum period is 9 cycles.
- `busy`=1 in cycles 1–7, 0 in DONE and IDLE.
- Reset values: state IDLE, `rd_en` 0, `rd_addr` 0, `busy` 0, `done` 0, `min_index` 0, `min_value` 0, tracker 0, counter 0.
- Reset mid-scan: return to IDLE next edge, no `done`, outputs forced to 0; `rd_data` returned after reset is ignored.
- Reset and `start` in the same cycle: reset wins.

## Structure

- Package `min_index_pkg` holds:
  - state enum `min_state_t` (IDLE, SCAN, DRAIN, DONE)
  - `N_CAND`=6
  - `IDX_W`=3
  - `LAST_IDX`=3'd5
- Sub-module `min_track`: running-min register pair (value, index) with strict-less compare. Inputs are load-first, sample valid, data, and index.
- Top level holds the FSM, address counter, valid pipe, and output registers.

## Test plan

- Distances [40,12,33,12,50,7], `start` at cycle 0 -> `rd_addr` 0..5 in cycles 1–6; `done` at cycle 8 with `min_index`=5, `min_value`=7.
- [9,9,9,9,9,9] -> index 0, value 9; all 16'hFFFF -> index 0, value 16'hFFFF.
- [30,4,20,4,8,4] -> index 1, value 4 (tie keeps lowest index).
- Reset asserted at cycle 4 of a scan -> no `done`; `busy` 0 and outputs 0 from cycle 5; a fresh `start` completes normally.
- `start` pulsed at cycles 3 and 8 -> both ignored, single `done` at cycle 8. `start` held high -> `done` at cycles 8, 17, 26. Prior result holds during the second scan until cycle 17.

Source files
------------

// File: rtl/min_index_seq_pkg.sv
`timescale 1ns/1ps
// Shared types and constants for the sequential argmin engine.
package min_index_pkg;

  // Scan sequencer states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } min_state_t;

  localparam int N_CAND = 6;
  localparam int IDX_W  = 3;
  localparam logic [IDX_W-1:0] LAST_IDX = 3'd5;

endpackage

// File: rtl/min_index_seq_if.sv
`timescale 1ns/1ps
// Bundle of the start/result handshake and the register-file read port.
// The slave side is the argmin engine; the master side is its environment.
interface min_index_seq_if import min_index_pkg::*; #(
  parameter int WIDTH = 16
);

  logic             start;
  logic             rd_en;
  logic [IDX_W-1:0] rd_addr;
  logic [WIDTH-1:0] rd_data;
  logic             busy;
  logic             done;
  logic [IDX_W-1:0] min_index;
  logic [WIDTH-1:0] min_value;

  modport master (
    output start,
    input  rd_en,
    input  rd_addr,
    output rd_data,
    input  busy,
    input  done,
    input  min_index,
    input  min_value
  );

  modport slave (
    input  start,
    output rd_en,
    output rd_addr,
    input  rd_data,
    output busy,
    output done,
    output min_index,
    output min_value
  );

endinterface

// File: rtl/min_index_seq_min_track.sv
`timescale 1ns/1ps
// Running-minimum tracker: holds the smallest value seen so far and its index.
// The first sample of a scan loads unconditionally; later samples replace the
// held pair only when strictly smaller, so ties keep the earlier (lower) index.
module min_track import min_index_pkg::*; #(
  parameter int WIDTH = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load_first,
  input  logic             sample_valid,
  input  logic [WIDTH-1:0] data,
  input  logic [IDX_W-1:0] idx,
  output logic [WIDTH-1:0] value_next,
  output logic [IDX_W-1:0] index_next
);

  logic [WIDTH-1:0] value_reg;
  logic [IDX_W-1:0] index_reg;

  // Select the tracker's next contents from the current sample
  always_comb begin
    value_next = value_reg;
    index_next = index_reg;
    if (sample_valid && (load_first || (data < value_reg))) begin
      value_next = data;
      index_next = idx;
    end
  end

  // Tracker register pair
  always_ff @(posedge clock) begin
    if (reset) begin
      value_reg <= '0;
      index_reg <= '0;
    end else begin
      value_reg <= value_next;
      index_reg <= index_next;
    end
  end

endmodule

// File: rtl/min_index_seq.sv
`timescale 1ns/1ps
// Sequential argmin over six distances read from a synchronous register file.
// One comparator is shared across six reads; the result is published with a
// one-cycle done pulse and held until the next scan completes.
module min_index_seq import min_index_pkg::*; #(
  parameter int WIDTH = 16
) (
  input  logic          clock,
  input  logic          reset,
  min_index_seq_if.slave bus
);

  min_state_t       state_reg, state_next;
  logic [IDX_W-1:0] cnt_reg, cnt_next;
  logic             rd_en_c;
  logic [IDX_W-1:0] rd_addr_c;
  logic             busy_c;
  logic             done_c;

  // Read data arrives one cycle after its strobe; this pipe tags it.
  logic             vld_reg;
  logic [IDX_W-1:0] vld_addr_reg;

  logic [WIDTH-1:0] trk_value_next;
  logic [IDX_W-1:0] trk_index_next;
  logic [WIDTH-1:0] min_value_reg;
  logic [IDX_W-1:0] min_index_reg;

  // Next-state and decoded outputs of the scan sequencer
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    rd_en_c    = 1'b0;
    rd_addr_c  = '0;
    busy_c     = 1'b0;
    done_c     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (bus.start) begin
          state_next = SCAN;
          cnt_next   = '0;
        end
      end
      SCAN: begin
        rd_en_c   = 1'b1;
        rd_addr_c = cnt_reg;
        busy_c    = 1'b1;
        if (cnt_reg == LAST_IDX) begin
          state_next = DRAIN;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + 3'd1;
        end
      end
      DRAIN: begin
        busy_c     = 1'b1;
        state_next = DONE;
      end
      DONE: begin
        done_c     = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Sequencer state and address counter
  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  // Delay the read strobe and address to line up with returned data;
  // reset clears it so data returning after an aborted scan is dropped.
  always_ff @(posedge clock) begin
    if (reset) begin
      vld_reg      <= 1'b0;
      vld_addr_reg <= '0;
    end else begin
      vld_reg      <= rd_en_c;
      vld_addr_reg <= rd_addr_c;
    end
  end

  min_track #(.WIDTH(WIDTH)) u_track (
    .clock        (clock),
    .reset        (reset),
    .load_first   (vld_reg && (vld_addr_reg == '0)),
    .sample_valid (vld_reg),
    .data         (bus.rd_data),
    .idx          (vld_addr_reg),
    .value_next   (trk_value_next),
    .index_next   (trk_index_next)
  );

  // Publish the result on the edge entering DONE. The last sample is compared
  // during DRAIN, so the tracker's next value is taken to make the result
  // visible in the same cycle as the done pulse.
  always_ff @(posedge clock) begin
    if (reset) begin
      min_value_reg <= '0;
      min_index_reg <= '0;
    end else if (state_reg == DRAIN) begin
      min_value_reg <= trk_value_next;
      min_index_reg <= trk_index_next;
    end
  end

  assign bus.rd_en     = rd_en_c;
  assign bus.rd_addr   = rd_addr_c;
  assign bus.busy      = busy_c;
  assign bus.done      = done_c;
  assign bus.min_index = min_index_reg;
  assign bus.min_value = min_value_reg;

endmodule

// File: tb/tb_min_index_seq.sv
`timescale 1ns/1ps
// Directed bench for min_index_seq: timing of one scan, argmin results,
// tie handling, mid-scan reset, ignored starts and back-to-back scans.
module tb_min_index_seq;

  typedef logic [15:0] vec_t [6];

  logic clk;
  logic rst;
  logic [15:0] mem [8];
  int total = 0;
  int bad   = 0;

  min_index_seq_if #(.WIDTH(16)) bus ();

  min_index_seq #(.WIDTH(16)) dut (
    .clock (clk),
    .reset (rst),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous-read register file holding the candidate distances
  always @(posedge clk) begin
    if (bus.rd_en) bus.rd_data <= mem[bus.rd_addr];
  end

  task automatic load_mem(input vec_t v);
    for (int i = 0; i < 6; i++) mem[i] = v[i];
  endtask

  task automatic test_reset;
    rst = 1'b1;
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (bus.rd_en !== 1'b0 || bus.rd_addr !== 3'd0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      bad++;
      $display("FAIL reset_ctrl: rd_en=%b rd_addr=%0d busy=%b done=%b, want 0 0 0 0",
               bus.rd_en, bus.rd_addr, bus.busy, bus.done);
    end
    total++;
    if (bus.min_index !== 3'd0 || bus.min_value !== 16'd0) begin
      bad++;
      $display("FAIL reset_out: min_index=%0d min_value=%0d, want 0 0", bus.min_index, bus.min_value);
    end
    $display("reset: min_index=%0d min_value=%0d", bus.min_index, bus.min_value);
  endtask

  // One full scan from an idle start, checking every cycle 1..9
  task automatic test_scan(input string name, input vec_t v, input logic [2:0] ei, input logic [15:0] ev);
    logic       exp_rd;
    logic [2:0] exp_addr;
    logic       exp_busy;
    logic       exp_done;
    load_mem(v);
    @(negedge clk);
    bus.start = 1'b1;
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      bus.start = 1'b0;
      exp_rd   = (c <= 6);
      exp_addr = exp_rd ? 3'(c - 1) : 3'd0;
      exp_busy = (c <= 7);
      exp_done = (c == 8);
      total++;
      if (bus.rd_en !== exp_rd || bus.rd_addr !== exp_addr) begin
        bad++;
        $display("FAIL %s_rd c%0d: rd_en=%b rd_addr=%0d, want %b %0d",
                 name, c, bus.rd_en, bus.rd_addr, exp_rd, exp_addr);
      end
      total++;
      if (bus.busy !== exp_busy || bus.done !== exp_done) begin
        bad++;
        $display("FAIL %s_flags c%0d: busy=%b done=%b, want %b %b",
                 name, c, bus.busy, bus.done, exp_busy, exp_done);
      end
      if (c >= 8) begin
        total++;
        if (bus.min_index !== ei || bus.min_value !== ev) begin
          bad++;
          $display("FAIL %s_result c%0d: min_index=%0d min_value=%0d, want %0d %0d",
                   name, c, bus.min_index, bus.min_value, ei, ev);
        end
      end
    end
    $display("scan %s: min_index=%0d min_value=%0d", name, bus.min_index, bus.min_value);
  endtask

  task automatic test_reset_mid_scan;
    load_mem('{16'd500, 16'd2, 16'd300, 16'd1, 16'd9, 16'd8});
    @(negedge clk);
    bus.start = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      bus.start = 1'b0;
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    total++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.rd_en !== 1'b0) begin
      bad++;
      $display("FAIL midreset_ctrl: busy=%b done=%b rd_en=%b, want 0 0 0", bus.busy, bus.done, bus.rd_en);
    end
    total++;
    if (bus.min_index !== 3'd0 || bus.min_value !== 16'd0) begin
      bad++;
      $display("FAIL midreset_out: min_index=%0d min_value=%0d, want 0 0", bus.min_index, bus.min_value);
    end
    for (int c = 6; c <= 14; c++) begin
      @(negedge clk);
      total++;
      if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
        bad++;
        $display("FAIL midreset_quiet c%0d: done=%b busy=%b, want 0 0", c, bus.done, bus.busy);
      end
    end
    $display("midreset: min_index=%0d min_value=%0d", bus.min_index, bus.min_value);
  endtask

  task automatic test_start_ignored;
    int n_done = 0;
    int done_cyc = -1;
    load_mem('{16'd100, 16'd200, 16'd3, 16'd300, 16'd3, 16'd9});
    @(negedge clk);
    bus.start = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (bus.done === 1'b1) begin
        n_done++;
        done_cyc = c;
      end
      bus.start = (c == 3 || c == 8);
    end
    bus.start = 1'b0;
    total++;
    if (n_done != 1 || done_cyc != 8) begin
      bad++;
      $display("FAIL ignore_start: done_count=%0d last_done_cycle=%0d, want 1 8", n_done, done_cyc);
    end
    total++;
    if (bus.min_index !== 3'd2 || bus.min_value !== 16'd3) begin
      bad++;
      $display("FAIL ignore_result: min_index=%0d min_value=%0d, want 2 3", bus.min_index, bus.min_value);
    end
    $display("ignore: min_index=%0d min_value=%0d dones=%0d", bus.min_index, bus.min_value, n_done);
  endtask

  task automatic test_back_to_back;
    logic       exp_done;
    logic [2:0] ei;
    logic [15:0] ev;
    load_mem('{16'd40, 16'd12, 16'd33, 16'd12, 16'd50, 16'd7});
    @(negedge clk);
    bus.start = 1'b1;
    for (int c = 1; c <= 27; c++) begin
      @(negedge clk);
      exp_done = (c == 8 || c == 17 || c == 26);
      total++;
      if (bus.done !== exp_done) begin
        bad++;
        $display("FAIL b2b_done c%0d: done=%b, want %b", c, bus.done, exp_done);
      end
      if (c >= 8) begin
        ei = (c < 17) ? 3'd5 : 3'd1;
        ev = (c < 17) ? 16'd7 : 16'd4;
        total++;
        if (bus.min_index !== ei || bus.min_value !== ev) begin
          bad++;
          $display("FAIL b2b_result c%0d: min_index=%0d min_value=%0d, want %0d %0d",
                   c, bus.min_index, bus.min_value, ei, ev);
        end
      end
      if (c == 9) load_mem('{16'd30, 16'd4, 16'd20, 16'd4, 16'd8, 16'd4});
      if (c == 26) bus.start = 1'b0;
    end
    $display("b2b: min_index=%0d min_value=%0d", bus.min_index, bus.min_value);
  endtask

  initial begin
    bus.start = 1'b0;
    rst = 1'b1;
    for (int i = 0; i < 8; i++) mem[i] = 16'd0;
    test_reset();
    test_scan("basic", '{16'd40, 16'd12, 16'd33, 16'd12, 16'd50, 16'd7}, 3'd5, 16'd7);
    test_scan("all9", '{16'd9, 16'd9, 16'd9, 16'd9, 16'd9, 16'd9}, 3'd0, 16'd9);
    test_scan("allmax", '{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF}, 3'd0, 16'hFFFF);
    test_scan("tie", '{16'd30, 16'd4, 16'd20, 16'd4, 16'd8, 16'd4}, 3'd1, 16'd4);
    test_reset_mid_scan();
    test_scan("after_reset", '{16'd500, 16'd2, 16'd300, 16'd1, 16'd9, 16'd8}, 3'd3, 16'd1);
    test_start_ignored();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
